// File: rtl/barrier_types.sv
// Shared types and helpers for the warp barrier controller: ID widths,
// the barrier table entry layout and a lowest-set-bit priority function.
package barrier_types;

   localparam int BARRIER_ID_W  = 16;
   localparam int BLOCK_ID_W    = 10;
   localparam int WARP_ID_W     = 6;
   localparam int MAX_WARPS     = 64;

   // Mask is sized for the largest block; bits at and above WARPS_PER_BLOCK stay 0.
   typedef struct packed {
      logic                    valid;
      logic                    complete;
      logic                    loaded;
      logic [BLOCK_ID_W-1:0]   block_id;
      logic [BARRIER_ID_W-1:0] barrier_id;
      logic [MAX_WARPS-1:0]    mask;
   } barrier_entry_t;

   function automatic logic [5:0] lowest_set(input logic [63:0] v);
      logic [5:0] idx;
      idx = '0;
      for (int i = 63; i >= 0; i--) begin
         if (v[i]) idx = 6'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/barrier_table.sv
// Barrier entry storage: key match / lowest-free allocation for arrivals,
// and lowest-index selection of complete entries awaiting release.
module barrier_table
   import barrier_types::*;
#(
   parameter int MAX_BARRIERS     = 16,
   parameter int MAX_BLOCKS       = 16,
   parameter int WARPS_PER_BLOCK  = 32,
   parameter int THREADS_PER_WARP = 32,
   parameter int IDX_W            = (MAX_BARRIERS > 1) ? $clog2(MAX_BARRIERS) : 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        i_arrive_valid,
   input  logic [BARRIER_ID_W-1:0]     i_arrive_barrier_id,
   input  logic [BLOCK_ID_W-1:0]       i_arrive_block_id,
   input  logic [WARP_ID_W-1:0]        i_arrive_warp_id,
   input  logic [THREADS_PER_WARP-1:0] i_arrive_thread_mask,
   output logic                        o_arrive_ready,
   input  logic                        i_load,
   input  logic                        i_free,
   input  logic [IDX_W-1:0]            i_free_idx,
   output logic                        o_sel_valid,
   output logic [IDX_W-1:0]            o_sel_idx,
   output logic [BLOCK_ID_W-1:0]       o_sel_block_id,
   output logic [BARRIER_ID_W-1:0]     o_sel_barrier_id,
   output logic [WARPS_PER_BLOCK-1:0]  o_sel_mask,
   output logic                        o_any_pending
);

   localparam logic [MAX_WARPS-1:0] FULL_MASK = (WARPS_PER_BLOCK >= MAX_WARPS) ? '1 :
      ((MAX_WARPS'(1) << WARPS_PER_BLOCK) - MAX_WARPS'(1));

   barrier_entry_t r_entries [MAX_BARRIERS];

   logic [MAX_BARRIERS-1:0] w_match_vec;
   logic [MAX_BARRIERS-1:0] w_free_vec;
   logic [MAX_BARRIERS-1:0] w_done_vec;
   logic [MAX_BARRIERS-1:0] w_pend_vec;
   logic                    w_match_any;
   logic [IDX_W-1:0]        w_match_idx;
   logic [IDX_W-1:0]        w_alloc_idx;
   logic [IDX_W-1:0]        w_sel_idx;
   logic                    w_in_range;
   logic                    w_accept;
   logic [MAX_WARPS-1:0]    w_onehot;
   logic [MAX_WARPS-1:0]    w_new_mask;
   logic                    w_new_complete;

   always_comb begin
      w_match_vec = '0;
      w_free_vec  = '0;
      w_done_vec  = '0;
      w_pend_vec  = '0;
      for (int i = 0; i < MAX_BARRIERS; i++) begin
         w_match_vec[i] = r_entries[i].valid &&
                          (r_entries[i].block_id == i_arrive_block_id) &&
                          (r_entries[i].barrier_id == i_arrive_barrier_id);
         w_free_vec[i]  = !r_entries[i].valid;
         w_done_vec[i]  = r_entries[i].valid && r_entries[i].complete && !r_entries[i].loaded;
         w_pend_vec[i]  = r_entries[i].valid && !r_entries[i].complete;
      end
   end

   assign w_match_any = |w_match_vec;
   assign w_match_idx = IDX_W'(lowest_set(64'(w_match_vec)));
   assign w_alloc_idx = IDX_W'(lowest_set(64'(w_free_vec)));
   assign w_sel_idx   = IDX_W'(lowest_set(64'(w_done_vec)));

   // A complete entry blocks further arrivals to its key until it is released.
   assign o_arrive_ready = w_match_any ? !r_entries[w_match_idx].complete : |w_free_vec;

   assign w_in_range = (32'(i_arrive_warp_id) < WARPS_PER_BLOCK) &&
                       (32'(i_arrive_block_id) < MAX_BLOCKS);
   assign w_accept   = i_arrive_valid && o_arrive_ready && (|i_arrive_thread_mask) && w_in_range;
   assign w_onehot   = MAX_WARPS'(1) << i_arrive_warp_id;
   assign w_new_mask = (w_match_any ? r_entries[w_match_idx].mask : '0) | w_onehot;
   assign w_new_complete = (w_new_mask == FULL_MASK);

   assign o_sel_valid      = |w_done_vec;
   assign o_sel_idx        = w_sel_idx;
   assign o_sel_block_id   = r_entries[w_sel_idx].block_id;
   assign o_sel_barrier_id = r_entries[w_sel_idx].barrier_id;
   assign o_sel_mask       = r_entries[w_sel_idx].mask[WARPS_PER_BLOCK-1:0];
   assign o_any_pending    = |w_pend_vec;

   // Free, load-mark and arrival always touch distinct entries in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < MAX_BARRIERS; i++) r_entries[i] <= '0;
      end else begin
         if (i_free) r_entries[i_free_idx].valid <= 1'b0;
         if (i_load) r_entries[w_sel_idx].loaded <= 1'b1;
         if (w_accept) begin
            if (w_match_any) begin
               r_entries[w_match_idx].mask     <= w_new_mask;
               r_entries[w_match_idx].complete <= w_new_complete;
            end else begin
               r_entries[w_alloc_idx] <= '{valid: 1'b1, complete: w_new_complete, loaded: 1'b0,
                                           block_id: i_arrive_block_id,
                                           barrier_id: i_arrive_barrier_id,
                                           mask: w_new_mask};
            end
         end
      end
   end

endmodule

// File: rtl/barrier_controller.sv
// Warp barrier synchronizer: arrival table, single-entry release register
// towards the warp scheduler, and completed-barrier / stall counters.
module barrier_controller
   import barrier_types::*;
#(
   parameter int MAX_BARRIERS     = 16,
   parameter int MAX_BLOCKS       = 16,
   parameter int WARPS_PER_BLOCK  = 32,
   parameter int THREADS_PER_WARP = 32
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [BARRIER_ID_W-1:0]     arrive_barrier_id,
   input  logic [THREADS_PER_WARP-1:0] arrive_thread_mask,
   input  logic [BLOCK_ID_W-1:0]       arrive_block_id,
   input  logic [WARP_ID_W-1:0]        arrive_warp_id,
   input  logic                        arrive_valid,
   output logic                        arrive_ready,
   output logic [BARRIER_ID_W-1:0]     release_barrier_id,
   output logic [BLOCK_ID_W-1:0]       release_block_id,
   output logic [WARPS_PER_BLOCK-1:0]  release_warp_mask,
   output logic                        release_valid,
   input  logic                        release_ready,
   output logic [31:0]                 barrier_count,
   output logic [31:0]                 stalled_cycle_count
);

   localparam int IDX_W = (MAX_BARRIERS > 1) ? $clog2(MAX_BARRIERS) : 1;

   logic                       r_rel_valid;
   logic [IDX_W-1:0]           r_rel_idx;
   logic [BLOCK_ID_W-1:0]      r_rel_block_id;
   logic [BARRIER_ID_W-1:0]    r_rel_barrier_id;
   logic [WARPS_PER_BLOCK-1:0] r_rel_mask;
   logic [31:0]                r_barrier_count;
   logic [31:0]                r_stalled_count;

   logic                       w_sel_valid;
   logic [IDX_W-1:0]           w_sel_idx;
   logic [BLOCK_ID_W-1:0]      w_sel_block_id;
   logic [BARRIER_ID_W-1:0]    w_sel_barrier_id;
   logic [WARPS_PER_BLOCK-1:0] w_sel_mask;
   logic                       w_any_pending;
   logic                       w_handshake;
   logic                       w_load;

   barrier_table #(
      .MAX_BARRIERS    (MAX_BARRIERS),
      .MAX_BLOCKS      (MAX_BLOCKS),
      .WARPS_PER_BLOCK (WARPS_PER_BLOCK),
      .THREADS_PER_WARP(THREADS_PER_WARP),
      .IDX_W           (IDX_W)
   ) u_table (
      .clk                 (clk),
      .rst_n               (rst_n),
      .i_arrive_valid      (arrive_valid),
      .i_arrive_barrier_id (arrive_barrier_id),
      .i_arrive_block_id   (arrive_block_id),
      .i_arrive_warp_id    (arrive_warp_id),
      .i_arrive_thread_mask(arrive_thread_mask),
      .o_arrive_ready      (arrive_ready),
      .i_load              (w_load),
      .i_free              (w_handshake),
      .i_free_idx          (r_rel_idx),
      .o_sel_valid         (w_sel_valid),
      .o_sel_idx           (w_sel_idx),
      .o_sel_block_id      (w_sel_block_id),
      .o_sel_barrier_id    (w_sel_barrier_id),
      .o_sel_mask          (w_sel_mask),
      .o_any_pending       (w_any_pending)
   );

   assign w_handshake = r_rel_valid && release_ready;
   // Reloading on the handshake edge gives back-to-back releases.
   assign w_load      = (!r_rel_valid || w_handshake) && w_sel_valid;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rel_valid      <= 1'b0;
         r_rel_idx        <= '0;
         r_rel_block_id   <= '0;
         r_rel_barrier_id <= '0;
         r_rel_mask       <= '0;
         r_barrier_count  <= '0;
         r_stalled_count  <= '0;
      end else begin
         if (w_load) begin
            r_rel_valid      <= 1'b1;
            r_rel_idx        <= w_sel_idx;
            r_rel_block_id   <= w_sel_block_id;
            r_rel_barrier_id <= w_sel_barrier_id;
            r_rel_mask       <= w_sel_mask;
         end else if (w_handshake) begin
            r_rel_valid <= 1'b0;
         end
         if (w_handshake)   r_barrier_count <= r_barrier_count + 32'd1;
         if (w_any_pending) r_stalled_count <= r_stalled_count + 32'd1;
      end
   end

   assign release_valid       = r_rel_valid;
   assign release_block_id    = r_rel_block_id;
   assign release_barrier_id  = r_rel_barrier_id;
   assign release_warp_mask   = r_rel_mask;
   assign barrier_count       = r_barrier_count;
   assign stalled_cycle_count = r_stalled_count;

endmodule

// File: tb/tb_barrier_controller.sv
// Directed bench for barrier_controller in an 8-warp, 16-entry configuration:
// a vector table for the single-barrier path plus hand-written multi-cycle sequences.
module tb_barrier_controller;

   localparam int WPB = 8;

   logic        clk;
   logic        rst_n;
   logic [15:0] arrive_barrier_id;
   logic [31:0] arrive_thread_mask;
   logic [9:0]  arrive_block_id;
   logic [5:0]  arrive_warp_id;
   logic        arrive_valid;
   logic        arrive_ready;
   logic [15:0] release_barrier_id;
   logic [9:0]  release_block_id;
   logic [WPB-1:0] release_warp_mask;
   logic        release_valid;
   logic        release_ready;
   logic [31:0] barrier_count;
   logic [31:0] stalled_cycle_count;

   int n_checks = 0;
   int n_errors = 0;

   barrier_controller #(
      .MAX_BARRIERS(16), .MAX_BLOCKS(16), .WARPS_PER_BLOCK(WPB), .THREADS_PER_WARP(32)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .arrive_barrier_id  (arrive_barrier_id),
      .arrive_thread_mask (arrive_thread_mask),
      .arrive_block_id    (arrive_block_id),
      .arrive_warp_id     (arrive_warp_id),
      .arrive_valid       (arrive_valid),
      .arrive_ready       (arrive_ready),
      .release_barrier_id (release_barrier_id),
      .release_block_id   (release_block_id),
      .release_warp_mask  (release_warp_mask),
      .release_valid      (release_valid),
      .release_ready      (release_ready),
      .barrier_count      (barrier_count),
      .stalled_cycle_count(stalled_cycle_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        valid;
      logic [9:0]  blk;
      logic [15:0] bar;
      logic [5:0]  warp;
      logic [31:0] tmask;
      logic        rr;
      logic        exp_ready;
      logic        exp_rv;
      logic [7:0]  exp_mask;
      logic [31:0] exp_bcount;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic v, input logic [9:0] b, input logic [15:0] br,
                          input logic [5:0] w, input logic [31:0] tm, input logic rr,
                          input logic er, input logic erv, input logic [7:0] em,
                          input logic [31:0] ebc);
      vec_t x;
      x.valid = v; x.blk = b; x.bar = br; x.warp = w; x.tmask = tm; x.rr = rr;
      x.exp_ready = er; x.exp_rv = erv; x.exp_mask = em; x.exp_bcount = ebc;
      vecs.push_back(x);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      arrive_valid = 1'b0;
      release_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic drive(input logic [9:0] b, input logic [15:0] br, input logic [5:0] w,
                        input logic [31:0] tm);
      arrive_valid = 1'b1;
      arrive_block_id = b;
      arrive_barrier_id = br;
      arrive_warp_id = w;
      arrive_thread_mask = tm;
   endtask

   // One arrival presented for one clock, with the expected combinational ready.
   task automatic arrive(input logic [9:0] b, input logic [15:0] br, input logic [5:0] w,
                         input logic [31:0] tm, input logic exp_rdy);
      drive(b, br, w, tm);
      #1;
      check($sformatf("arrive_ready b%0d bar%0d w%0d", b, br, w), 64'(arrive_ready), 64'(exp_rdy));
      @(posedge clk);
      #1;
      arrive_valid = 1'b0;
   endtask

   // Ready probe without a clock edge.
   task automatic probe(input logic [9:0] b, input logic [15:0] br, input logic exp_rdy);
      drive(b, br, 6'd0, 32'hFFFF_FFFF);
      #1;
      check($sformatf("probe_ready b%0d bar%0d", b, br), 64'(arrive_ready), 64'(exp_rdy));
      arrive_valid = 1'b0;
   endtask

   // Waits for a release with release_ready high, checks it, then lets the handshake edge pass.
   task automatic wait_release(input logic [9:0] b, input logic [15:0] br, input logic [7:0] m);
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (!seen) begin
            if (release_valid) seen = 1'b1;
            else idle(1);
         end
      end
      n_checks++;
      if (!seen) begin
         n_errors++;
         $display("FAIL release_timeout b%0d bar%0d: got release_valid=0 expected 1", b, br);
      end else begin
         check($sformatf("rel_block b%0d", b), 64'(release_block_id), 64'(b));
         check($sformatf("rel_barrier b%0d", b), 64'(release_barrier_id), 64'(br));
         check($sformatf("rel_mask b%0d", b), 64'(release_warp_mask), 64'(m));
         idle(1);
      end
   endtask

   initial begin
      arrive_barrier_id = '0;
      arrive_thread_mask = '0;
      arrive_block_id = '0;
      arrive_warp_id = '0;
      arrive_valid = 1'b0;
      release_ready = 1'b1;

      // Reset and idle
      do_reset();
      idle(5);
      check("reset arrive_ready", 64'(arrive_ready), 64'd1);
      check("reset release_valid", 64'(release_valid), 64'd0);
      check("reset release_block", 64'(release_block_id), 64'd0);
      check("reset release_mask", 64'(release_warp_mask), 64'd0);
      check("reset barrier_count", 64'(barrier_count), 64'd0);
      check("reset stalled_count", 64'(stalled_cycle_count), 64'd0);

      // Block 1 barrier 1 with gaps, duplicate, zero-mask drop, held release and drops
      add_vec(1, 1, 1, 0, 32'hFFFF_FFFF, 1, 1, 0, 8'h00, 0);
      add_vec(0, 0, 0, 0, 32'h0,         1, 1, 0, 8'h00, 0);
      add_vec(1, 1, 1, 1, 32'h0000_0001, 1, 1, 0, 8'h00, 0);
      add_vec(1, 1, 1, 1, 32'h0000_0001, 1, 1, 0, 8'h00, 0);
      add_vec(1, 1, 1, 2, 32'h0,         1, 1, 0, 8'h00, 0);
      add_vec(1, 1, 1, 2, 32'h8000_0000, 1, 1, 0, 8'h00, 0);
      add_vec(0, 0, 0, 0, 32'h0,         1, 1, 0, 8'h00, 0);
      add_vec(1, 1, 1, 3, 32'hFFFF_FFFF, 1, 1, 0, 8'h00, 0);
      add_vec(1, 1, 1, 4, 32'hFFFF_FFFF, 1, 1, 0, 8'h00, 0);
      add_vec(1, 1, 1, 5, 32'hFFFF_FFFF, 1, 1, 0, 8'h00, 0);
      add_vec(1, 1, 1, 6, 32'hFFFF_FFFF, 1, 1, 0, 8'h00, 0);
      add_vec(1, 1, 1, 7, 32'hFFFF_FFFF, 1, 1, 0, 8'h00, 0);
      add_vec(0, 0, 0, 0, 32'h0,         0, 1, 1, 8'hFF, 0);
      add_vec(1, 1, 1, 0, 32'hFFFF_FFFF, 0, 0, 1, 8'hFF, 0);
      add_vec(0, 0, 0, 0, 32'h0,         1, 1, 0, 8'h00, 1);
      add_vec(1, 16, 1, 0, 32'hFFFF_FFFF, 1, 1, 0, 8'h00, 1);
      add_vec(1, 1, 1, 8, 32'hFFFF_FFFF, 1, 1, 0, 8'h00, 1);
      add_vec(0, 0, 0, 0, 32'h0,         1, 1, 0, 8'h00, 1);

      foreach (vecs[k]) begin
         arrive_valid = vecs[k].valid;
         arrive_block_id = vecs[k].blk;
         arrive_barrier_id = vecs[k].bar;
         arrive_warp_id = vecs[k].warp;
         arrive_thread_mask = vecs[k].tmask;
         release_ready = vecs[k].rr;
         #1;
         check($sformatf("vec%0d arrive_ready", k), 64'(arrive_ready), 64'(vecs[k].exp_ready));
         @(posedge clk);
         #1;
         arrive_valid = 1'b0;
         check($sformatf("vec%0d release_valid", k), 64'(release_valid), 64'(vecs[k].exp_rv));
         if (vecs[k].exp_rv) begin
            check($sformatf("vec%0d release_block", k), 64'(release_block_id), 64'd1);
            check($sformatf("vec%0d release_barrier", k), 64'(release_barrier_id), 64'd1);
            check($sformatf("vec%0d release_mask", k), 64'(release_warp_mask), 64'(vecs[k].exp_mask));
         end
         check($sformatf("vec%0d barrier_count", k), 64'(barrier_count), 64'(vecs[k].exp_bcount));
      end
      release_ready = 1'b1;
      check("table stalled_count", 64'(stalled_cycle_count), 64'd11);

      // Partial barrier left behind must vanish on reset; then a long stall on block 2
      arrive(10'd9, 16'd9, 6'd0, 32'hFFFF_FFFF, 1'b1);
      do_reset();
      for (int w = 0; w < 4; w++) arrive(10'd2, 16'd2, 6'(w), 32'hFFFF_FFFF, 1'b1);
      check("stall after 4 warps", 64'(stalled_cycle_count), 64'd3);
      for (int c = 0; c < 50; c++) begin
         idle(1);
         check($sformatf("stall no release c%0d", c), 64'(release_valid), 64'd0);
      end
      check("stall after 50 cycles", 64'(stalled_cycle_count), 64'd53);
      for (int w = 4; w < 8; w++) arrive(10'd2, 16'd2, 6'(w), 32'hFFFF_FFFF, 1'b1);
      wait_release(10'd2, 16'd2, 8'hFF);
      check("stall final", 64'(stalled_cycle_count), 64'd57);
      check("stall barrier_count", 64'(barrier_count), 64'd1);

      // Blocks 3 and 4 interleaved on barrier 3
      for (int w = 0; w < 7; w++) begin
         arrive(10'd3, 16'd3, 6'(w), 32'hFFFF_FFFF, 1'b1);
         arrive(10'd4, 16'd3, 6'(w), 32'hFFFF_FFFF, 1'b1);
      end
      check("interleave no early release", 64'(release_valid), 64'd0);
      arrive(10'd3, 16'd3, 6'd7, 32'hFFFF_FFFF, 1'b1);
      wait_release(10'd3, 16'd3, 8'hFF);
      for (int c = 0; c < 5; c++) begin
         idle(1);
         check($sformatf("block4 held c%0d", c), 64'(release_valid), 64'd0);
      end
      arrive(10'd4, 16'd3, 6'd7, 32'hFFFF_FFFF, 1'b1);
      wait_release(10'd4, 16'd3, 8'hFF);
      check("interleave barrier_count", 64'(barrier_count), 64'd3);

      // Back-pressure: block 7 held while blocks 6 then 5 complete; lowest entry wins after
      arrive(10'd5, 16'd9, 6'd0, 32'hFFFF_FFFF, 1'b1);
      arrive(10'd6, 16'd9, 6'd0, 32'hFFFF_FFFF, 1'b1);
      arrive(10'd7, 16'd9, 6'd0, 32'hFFFF_FFFF, 1'b1);
      release_ready = 1'b0;
      for (int w = 1; w < 8; w++) arrive(10'd7, 16'd9, 6'(w), 32'hFFFF_FFFF, 1'b1);
      for (int w = 1; w < 8; w++) arrive(10'd6, 16'd9, 6'(w), 32'hFFFF_FFFF, 1'b1);
      for (int w = 1; w < 8; w++) arrive(10'd5, 16'd9, 6'(w), 32'hFFFF_FFFF, 1'b1);
      for (int c = 0; c < 5; c++) begin
         idle(1);
         check($sformatf("hold valid c%0d", c), 64'(release_valid), 64'd1);
         check($sformatf("hold block c%0d", c), 64'(release_block_id), 64'd7);
         check($sformatf("hold mask c%0d", c), 64'(release_warp_mask), 64'hFF);
      end
      check("hold barrier_count", 64'(barrier_count), 64'd3);
      release_ready = 1'b1;
      idle(1);
      check("b2b first valid", 64'(release_valid), 64'd1);
      check("b2b first block", 64'(release_block_id), 64'd5);
      check("b2b first count", 64'(barrier_count), 64'd4);
      idle(1);
      check("b2b second valid", 64'(release_valid), 64'd1);
      check("b2b second block", 64'(release_block_id), 64'd6);
      check("b2b second count", 64'(barrier_count), 64'd5);
      idle(1);
      check("b2b drained valid", 64'(release_valid), 64'd0);
      check("b2b drained count", 64'(barrier_count), 64'd6);

      // Table full: new key refused, existing key accepted, slot reusable after release
      for (int b = 0; b < 16; b++) arrive(10'(b), 16'd20, 6'd0, 32'hFFFF_FFFF, 1'b1);
      probe(10'd0, 16'd21, 1'b0);
      arrive(10'd3, 16'd20, 6'd1, 32'hFFFF_FFFF, 1'b1);
      arrive(10'd3, 16'd20, 6'd1, 32'hFFFF_FFFF, 1'b1);
      arrive(10'd3, 16'd20, 6'd2, 32'h0, 1'b1);
      for (int w = 1; w < 8; w++) arrive(10'd0, 16'd20, 6'(w), 32'hFFFF_FFFF, 1'b1);
      wait_release(10'd0, 16'd20, 8'hFF);
      check("full barrier_count", 64'(barrier_count), 64'd7);
      probe(10'd0, 16'd21, 1'b1);
      for (int w = 3; w < 8; w++) arrive(10'd3, 16'd20, 6'(w), 32'hFFFF_FFFF, 1'b1);
      for (int c = 0; c < 5; c++) begin
         idle(1);
         check($sformatf("zero mask dropped c%0d", c), 64'(release_valid), 64'd0);
      end
      arrive(10'd3, 16'd20, 6'd2, 32'hFFFF_FFFF, 1'b1);
      wait_release(10'd3, 16'd20, 8'hFF);
      check("final barrier_count", 64'(barrier_count), 64'd8);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/barrier_controller.md
Name: barrier_controller

Overview:
- Block-level warp barrier synchronizer for the SM front end.
- Warps arrive with (block_id, barrier_id, warp_id); the controller tracks arrivals per (block, barrier) pair in a small table.
- When every warp of the block has arrived, it emits one release carrying the warp mask to the warp scheduler over a valid/ready handshake.
- Keeps performance counters for completed barriers and barrier stall cycles.

Parameters:
- MAX_BARRIERS, 16: number of concurrently tracked (block, barrier) entries.
- MAX_BLOCKS, 16: legal block_id range is 0..MAX_BLOCKS-1.
- WARPS_PER_BLOCK, 32: warps per block, 1..64; the full mask is all ones of this width.
- THREADS_PER_WARP, 32: arrive_thread_mask width; must be 32.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- arrive_barrier_id  in  16  barrier identifier.
- arrive_thread_mask  in  32  active threads of the arriving warp.
- arrive_block_id  in  10  block of the arriving warp.
- arrive_warp_id  in  6  warp index within the block.
- arrive_valid  in  1  arrival request.
- arrive_ready  out  1  arrival accepted when valid&&ready.
- release_barrier_id  out  16  barrier being released.
- release_block_id  out  10  block being released.
- release_warp_mask  out  WARPS_PER_BLOCK  warps to wake.
- release_valid  out  1  release available.
- release_ready  in  1  consumer accepts release.
- barrier_count  out  32  completed releases.
- stalled_cycle_count  out  32  barrier stall cycles.

Behaviour:
- Reset (rst_n low at a rising edge):
  - All entries invalid; release_valid=0; release ids and mask 0; both counters 0.
  - arrive_ready=1 from the first cycle after reset.
  - Reset mid-operation discards all pending arrivals and any held release.
- Entry contents: valid, complete, block_id, barrier_id, arrived mask [WARPS_PER_BLOCK-1:0].
- arrive_ready is combinational and is 0 only when either:
  - no valid entry matches (block_id, barrier_id) and no free entry exists; or
  - the matching entry is complete but not yet released.
- Accepted arrival (arrive_valid && arrive_ready at edge N):
  - If a matching entry exists, set mask bit warp_id in it.
  - Otherwise allocate the lowest-index free entry, with mask = onehot(warp_id).
  - Repeated arrival of the same warp is idempotent.
  - Dropped (accepted, no state change): arrive_thread_mask==0, warp_id>=WARPS_PER_BLOCK, or block_id>=MAX_BLOCKS.
- Completion: if the updated mask equals all ones, the entry's complete flag is set at edge N.
- Release register:
  - Loads on the edge when it is empty or being handshaken and a complete, not-yet-loaded entry exists.
  - If several entries are complete, the lowest index wins.
  - Minimum latency: arrival edge N -> release_valid high after edge N+1.
  - Outputs hold stable while release_valid && !release_ready.
- Release handshake (release_valid && release_ready at an edge):
  - The source entry is invalidated (freed).
  - barrier_count increments by 1, wrapping at 2^32.
  - release_valid drops unless the next complete entry loads on the same edge, which allows back-to-back releases.
- stalled_cycle_count increments (wrapping) every cycle in which at least one valid, non-complete entry exists.
- Same-cycle arrival and release of different entries are both honoured. A slot freed at edge E is allocatable from cycle E+1.

Decomposition:
- Package barrier_types holds:
  - barrier_entry_t struct (valid, complete, loaded, block_id, barrier_id, mask);
  - ID width constants (16/10/6);
  - the lowest-set-bit index function.
- One natural sub-module, barrier_table: entry storage, match/allocate, and complete-entry priority select.
- The top level holds the release register and the counters.

Test Plan:
- Reset then idle 5 cycles -> arrive_ready=1, release_valid=0, barrier_count=0, stalled_cycle_count=0.
- Block 1, barrier 1: warps 0..7 arrive with gaps (8-warp configuration) -> no release until warp 7; then release_barrier_id=1, release_block_id=1, mask=8'hFF; barrier_count=1 after handshake.
- Warps 0..3 of block 2 only -> release_valid stays 0 for 50 cycles; stalled_cycle_count advances by 1 per cycle; completing warps 4..7 then releases with mask FF.
- Blocks 3 and 4 interleaved, same barrier_id 3 -> independent entries; each releases only when its own 8 warps are in; barrier_count increases by 2.
- Hold release_ready=0 with two complete barriers -> first release outputs stable; raising ready gives releases on consecutive edges, lowest entry first.
- Fill all MAX_BARRIERS entries with partial arrivals -> new-key arrive_ready=0 while an arrival to an existing key is still accepted; the slot frees after a completion handshake. Duplicate warp arrival and thread_mask=0 cause no change.
